// File: rtl/dummy_pipe.sv
// dummy_pipe: elastic DEPTH-stage valid/ready register pipeline.
// Each accepted word is transformed on entry (pass / invert / increment /
// xor-accumulate), then walks the stages one per cycle whenever the stage
// ahead is free or draining. A saturating counter tallies output transfers.
// flush_i empties the pipeline and clears the accumulator and counter.
module dummy_pipe #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              flush_i,
  input  logic [1:0]        mode_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_in_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_out_o,
  output logic [CNT_W-1:0]  cnt_o
);

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_INV  = 2'b01;
  localparam logic [1:0] MODE_INC  = 2'b10;
  localparam logic [1:0] MODE_XACC = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Entry transform. For xor-accumulate the result is also the new
  // accumulator value, so the caller reuses it to update r_acc.
  function automatic logic [DATA_W-1:0] f_transform(
    input logic [1:0]        mode,
    input logic [DATA_W-1:0] x,
    input logic [DATA_W-1:0] acc
  );
    logic [DATA_W-1:0] y;
    case (mode)
      MODE_PASS: y = x;
      MODE_INV:  y = ~x;
      MODE_INC:  y = x + DATA_W'(1'b1);
      MODE_XACC: y = acc ^ x;
      default:   y = x;
    endcase
    return y;
  endfunction

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] c);
    logic [CNT_W-1:0] n;
    if (c == CNT_MAX) begin
      n = c;
    end else begin
      n = c + CNT_W'(1'b1);
    end
    return n;
  endfunction

  // Stage state: index DEPTH-1 is the output stage.
  logic [DEPTH-1:0]  r_valid;
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [DATA_W-1:0] r_acc;
  logic [CNT_W-1:0]  r_cnt;

  // w_rdy[k]: stage k may load this cycle; w_rdy[DEPTH] is the sink.
  logic [DEPTH:0]    w_rdy;
  logic              w_accept;
  logic              w_out_xfer;
  logic [DATA_W-1:0] w_stage0_data;

  // Ready chain: stage k can load if it or any stage downstream of it is
  // empty, or the sink is taking the output word. Written as a reduction per
  // stage so no signal feeds back into itself.
  always_comb begin
    logic t_rdy;
    w_rdy = '0;
    for (int k = 0; k <= DEPTH; k++) begin
      t_rdy = ready_i;
      for (int j = k; j < DEPTH; j++) begin
        t_rdy = t_rdy | ~r_valid[j];
      end
      w_rdy[k] = t_rdy;
    end
  end

  // Handshake qualifiers and the transformed input word.
  always_comb begin
    ready_o       = w_rdy[0] & ~flush_i;
    w_accept      = valid_i & ready_o;
    w_out_xfer    = r_valid[DEPTH-1] & ready_i;
    w_stage0_data = f_transform(mode_i, data_in_i, r_acc);
  end

  // Pipeline advance, accumulator and transfer counter; flush clears the
  // control state but leaves stage data alone.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_valid <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_data[k] <= '0;
      end
      r_acc <= '0;
      r_cnt <= '0;
    end else if (flush_i) begin
      r_valid <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_rdy[0]) begin
        r_valid[0] <= valid_i;
        if (valid_i) begin
          r_data[0] <= w_stage0_data;
        end
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (w_rdy[k]) begin
          r_valid[k] <= r_valid[k-1];
          r_data[k]  <= r_data[k-1];
        end
      end
      if (w_accept && (mode_i == MODE_XACC)) begin
        r_acc <= w_stage0_data;
      end
      if (w_out_xfer) begin
        r_cnt <= f_sat_inc(r_cnt);
      end
    end
  end

  // Outputs come straight from the output stage registers.
  always_comb begin
    valid_o    = r_valid[DEPTH-1];
    data_out_o = r_data[DEPTH-1];
    cnt_o      = r_cnt;
  end

endmodule

// File: tb/tb_dummy_pipe.sv
// Bench for dummy_pipe: directed scenarios plus a randomized run, all
// checked cycle by cycle against a queue-based reference model.
module tb_dummy_pipe;

  localparam int DATA_W  = 128;
  localparam int DEPTH   = 2;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;

  logic              clk_i;
  logic              reset_n_i;
  logic              flush_i;
  logic [1:0]        mode_i;
  logic              valid_i;
  logic              ready_o;
  logic [DATA_W-1:0] data_in_i;
  logic              valid_o;
  logic              ready_i;
  logic [DATA_W-1:0] data_out_o;
  logic [CNT_W-1:0]  cnt_o;

  dummy_pipe #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .flush_i(flush_i), .mode_i(mode_i),
    .valid_i(valid_i), .ready_o(ready_o), .data_in_i(data_in_i),
    .valid_o(valid_o), .ready_i(ready_i), .data_out_o(data_out_o), .cnt_o(cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference model: words in flight with the cycle they were accepted.
  typedef struct { logic [DATA_W-1:0] d; int ts; } ent_t;
  ent_t              mq[$];
  logic [DATA_W-1:0] outs[$];
  logic [DATA_W-1:0] m_acc;
  int                m_cnt;
  int                cyc;
  int                checks;
  int                errors;
  logic              last_acc;
  int                first_out_cyc;

  function automatic logic [DATA_W-1:0] rnd_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic model_clear();
    mq.delete();
    m_acc = '0;
    m_cnt = 0;
  endtask

  // One clock cycle: drive inputs, compare outputs mid-cycle, advance model.
  // The oldest in-flight word never waits on anything, so it reaches the
  // output exactly DEPTH cycles after acceptance; occupancy alone decides
  // whether input can be taken.
  task automatic do_cycle(input logic v, input logic [1:0] m, input logic [DATA_W-1:0] d,
                          input logic rdy, input logic fl);
    logic              exp_ready;
    logic              exp_valid;
    logic [DATA_W-1:0] x;
    ent_t              e;
    valid_i = v; mode_i = m; data_in_i = d; ready_i = rdy; flush_i = fl;
    @(negedge clk_i);
    exp_ready = !fl && ((mq.size() < DEPTH) || rdy);
    exp_valid = (mq.size() > 0) && ((cyc - mq[0].ts) >= DEPTH);
    checks++;
    if (ready_o !== exp_ready) begin
      errors++;
      $display("FAIL ready_o cyc=%0d got %b want %b", cyc, ready_o, exp_ready);
    end
    checks++;
    if (valid_o !== exp_valid) begin
      errors++;
      $display("FAIL valid_o cyc=%0d got %b want %b", cyc, valid_o, exp_valid);
    end
    checks++;
    if (cnt_o !== CNT_W'(m_cnt)) begin
      errors++;
      $display("FAIL cnt_o cyc=%0d got %0d want %0d", cyc, cnt_o, m_cnt);
    end
    if (exp_valid) begin
      checks++;
      if (data_out_o !== mq[0].d) begin
        errors++;
        $display("FAIL data_out_o cyc=%0d got %h want %h", cyc, data_out_o, mq[0].d);
      end
    end
    if ((valid_o === 1'b1) && (first_out_cyc < 0)) first_out_cyc = cyc;
    if ((valid_o === 1'b1) && rdy) outs.push_back(data_out_o);
    if (exp_valid && rdy) begin
      void'(mq.pop_front());
      if (!fl && (m_cnt < CNT_MAX)) m_cnt++;
    end
    last_acc = v && exp_ready;
    if (last_acc) begin
      case (m)
        2'b00: x = d;
        2'b01: x = ~d;
        2'b10: x = d + 128'd1;
        default: begin m_acc = m_acc ^ d; x = m_acc; end
      endcase
      e.d = x; e.ts = cyc;
      mq.push_back(e);
    end
    if (fl) model_clear();
    cyc++;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 2'b00, '0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    mode_i = 2'b00; data_in_i = '0;
    #3;
    checks++;
    if ((valid_o !== 1'b0) || (data_out_o !== '0) || (cnt_o !== 4'd0)) begin
      errors++;
      $display("FAIL reset_state got v=%b d=%h c=%0d want 0/0/0", valid_o, data_out_o, cnt_o);
    end
    @(posedge clk_i); #1;
    reset_n_i = 1'b1;
    #1;
    checks++;
    if (ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b want 1", ready_o);
    end
    model_clear();
  endtask

  task automatic test_stream();
    int base; int acc_cyc;
    base = outs.size(); first_out_cyc = -1; acc_cyc = cyc;
    for (int i = 0; i < 8; i++) do_cycle(1'b1, 2'b00, 128'(i), 1'b1, 1'b0);
    idle(4);
    checks++;
    if (first_out_cyc - acc_cyc != DEPTH) begin
      errors++;
      $display("FAIL stream_latency got %0d want %0d", first_out_cyc - acc_cyc, DEPTH);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (outs[base+i] !== 128'(i)) begin
        errors++;
        $display("FAIL stream_word%0d got %h want %h", i, outs[base+i], 128'(i));
      end
    end
    checks++;
    if (cnt_o !== 4'd8) begin
      errors++;
      $display("FAIL stream_cnt got %0d want 8", cnt_o);
    end
  endtask

  task automatic test_modes();
    int base;
    logic [DATA_W-1:0] ones;
    ones = '1;
    do_cycle(1'b0, 2'b00, '0, 1'b1, 1'b1);
    base = outs.size();
    do_cycle(1'b1, 2'b01, '0, 1'b1, 1'b0);
    do_cycle(1'b1, 2'b10, ones, 1'b1, 1'b0);
    idle(4);
    checks++;
    if ((outs.size() != base + 2) || (outs[base] !== ones) || (outs[base+1] !== '0)) begin
      errors++;
      $display("FAIL modes got n=%0d %h %h want 2 ones zero", outs.size() - base,
               outs[base], outs[base+1]);
    end
  endtask

  task automatic test_xor();
    int base;
    do_cycle(1'b0, 2'b00, '0, 1'b1, 1'b1);
    base = outs.size();
    do_cycle(1'b1, 2'b11, 128'h3, 1'b1, 1'b0);
    do_cycle(1'b1, 2'b11, 128'h5, 1'b1, 1'b0);
    do_cycle(1'b1, 2'b11, 128'h6, 1'b1, 1'b0);
    idle(4);
    do_cycle(1'b0, 2'b00, '0, 1'b1, 1'b1);
    do_cycle(1'b1, 2'b11, 128'h9, 1'b1, 1'b0);
    idle(4);
    checks++;
    if ((outs.size() != base + 4) || (outs[base] !== 128'h3) || (outs[base+1] !== 128'h6) ||
        (outs[base+2] !== 128'h0) || (outs[base+3] !== 128'h9)) begin
      errors++;
      $display("FAIL xor_acc got n=%0d %h %h %h %h want 3 6 0 9", outs.size() - base,
               outs[base], outs[base+1], outs[base+2], outs[base+3]);
    end
  endtask

  task automatic test_stall();
    int base; int idx;
    logic [DATA_W-1:0] w[8];
    for (int k = 0; k < 8; k++) w[k] = rnd_word();
    do_cycle(1'b0, 2'b00, '0, 1'b1, 1'b1);
    base = outs.size(); idx = 0;
    for (int c = 0; c < 5; c++) begin
      do_cycle(1'b1, 2'b00, w[idx], 1'b0, 1'b0);
      if (last_acc) idx++;
    end
    checks++;
    if ((idx != DEPTH) || (ready_o !== 1'b0) || (data_out_o !== w[0])) begin
      errors++;
      $display("FAIL stall_hold got acc=%0d rdy=%b d=%h want %0d 0 %h", idx, ready_o,
               data_out_o, DEPTH, w[0]);
    end
    for (int c = 0; (c < 30) && (idx < 8); c++) begin
      do_cycle(1'b1, 2'b00, w[idx], 1'b1, 1'b0);
      if (last_acc) idx++;
    end
    idle(4);
    checks++;
    if (outs.size() != base + 8) begin
      errors++;
      $display("FAIL stall_count got %0d want 8", outs.size() - base);
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (outs[base+k] !== w[k]) begin
          errors++;
          $display("FAIL stall_order%0d got %h want %h", k, outs[base+k], w[k]);
        end
      end
    end
  endtask

  task automatic test_saturate();
    do_cycle(1'b0, 2'b00, '0, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) do_cycle(1'b1, 2'b00, rnd_word(), 1'b1, 1'b0);
    idle(4);
    checks++;
    if (cnt_o !== 4'd15) begin
      errors++;
      $display("FAIL cnt_saturate got %0d want 15", cnt_o);
    end
    do_cycle(1'b0, 2'b00, '0, 1'b1, 1'b1);
    checks++;
    if (cnt_o !== 4'd0) begin
      errors++;
      $display("FAIL cnt_flush got %0d want 0", cnt_o);
    end
  endtask

  task automatic test_random();
    logic v; logic r; logic f;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 9) < 7);
      r = ($urandom_range(0, 9) < 6);
      f = ($urandom_range(0, 99) < 3);
      do_cycle(v, 2'($urandom_range(0, 3)), rnd_word(), r, f);
    end
    idle(8);
    checks++;
    if (mq.size() != 0) begin
      errors++;
      $display("FAIL random_drain got %0d left want 0", mq.size());
    end
  endtask

  task automatic test_reset_mid();
    int base;
    do_cycle(1'b0, 2'b00, '0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) do_cycle(1'b1, 2'b00, rnd_word(), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) do_cycle(1'b1, 2'b00, rnd_word(), 1'b0, 1'b0);
    reset_n_i = 1'b0;
    #2;
    checks++;
    if ((valid_o !== 1'b0) || (cnt_o !== 4'd0) || (data_out_o !== '0)) begin
      errors++;
      $display("FAIL reset_async got v=%b c=%0d d=%h want 0 0 0", valid_o, cnt_o, data_out_o);
    end
    model_clear();
    @(posedge clk_i); #1;
    reset_n_i = 1'b1;
    base = outs.size();
    idle(3);
    do_cycle(1'b1, 2'b00, 128'hABC, 1'b1, 1'b0);
    idle(4);
    checks++;
    if ((outs.size() != base + 1) || (outs[base] !== 128'hABC)) begin
      errors++;
      $display("FAIL reset_resume got n=%0d want 1 word abc", outs.size() - base);
    end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; first_out_cyc = -1; last_acc = 1'b0;
    model_clear();
    test_reset();
    test_stream();
    test_modes();
    test_xor();
    test_stall();
    test_saturate();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
